dvs_event_reader: RTL and testbench

- Consumes the packed difference lines the capture side writes to DDR.
- The PS copies one 128-pixel line back from DDR into a BRAM buffer. This block scans that buffer and emits one event per changed pixel on a valid/ready stream: x, y and polarity.
- It sits between the PS line-transfer DMA (BRAM port B) and the downstream event sink (spike encoder / UART packetiser).
- Per-line handshake with the PS: line_ready in, line_done out.

---
 rtl/dvs_pkg.sv | 38 +++
 rtl/dvs_event_slot.sv | 39 +++
 rtl/dvs_event_reader.sv | 192 +++++++++++++++++++
 tb/tb_dvs_event_reader.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvs_pkg.sv
// Shared definitions for the DVS event reader: colour codes, word bit-slices,
// FSM state encoding and event field widths.
package dvs_pkg;

   localparam logic [1:0] COL_NONE = 2'b00;
   localparam logic [1:0] COL_POS  = 2'b01;
   localparam logic [1:0] COL_NEG  = 2'b10;
   localparam logic [1:0] COL_RSV  = 2'b11;

   // Each 32-bit word packs two pixels as {ref[7:0], colour[1:0], pixel[5:0]}.
   localparam int REF_W      = 8;
   localparam int COL_W      = 2;
   localparam int PIX_W      = 6;
   localparam int HI_REF_LSB = 24;
   localparam int HI_COL_LSB = 22;
   localparam int HI_PIX_LSB = 16;
   localparam int LO_REF_LSB = 8;
   localparam int LO_COL_LSB = 6;
   localparam int LO_PIX_LSB = 0;

   localparam int COORD_W_DEF = 7;
   localparam int TS_W        = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_EMIT_HI,
      S_EMIT_LO,
      S_DONE
   } state_t;

   // Reserved colour 11 is dropped exactly like "no change".
   function automatic logic col_is_event(input logic [COL_W-1:0] col);
      return (col == COL_POS) || (col == COL_NEG);
   endfunction

endpackage

// File: rtl/dvs_event_slot.sv
// Single-entry output register for the event stream; contents are held while
// valid is high and the sink is not ready.
module dvs_event_slot #(
   parameter int W = 15
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         free_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   // A new event may be loaded in the same cycle the held one is taken.
   assign free_o  = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/dvs_event_reader.sv
// Scans one packed difference line from BRAM and emits {polarity, y, x} events.
// Optional build macro DVS_EVENT_TIMESTAMP_EN adds a 16-bit ev_ts per event.
//
// state   | meaning
// IDLE    | waiting for line_ready
// FETCH   | word address presented to BRAM
// WAIT    | BRAM data returned, colours latched
// EMIT_HI | upper pixel (x = 2*idx) event offered to the output slot
// EMIT_LO | lower pixel (x = 2*idx+1) event offered, then next word or DONE
// DONE    | line_done pulse, y advances
module dvs_event_reader
   import dvs_pkg::*;
#(
   parameter int LINE_WORDS = 64,
   parameter int NUM_LINES  = 128,
   parameter int ADDR_W     = 17,
   parameter int COORD_W    = COORD_W_DEF
) (
   input  logic                 pclk,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic                 line_ready,
   output logic                 line_done,
   output logic                 frame_done,
   output logic                 line_overrun,
   output logic [ADDR_W-1:0]    bram_addr,
   output logic                 bram_clk,
   input  logic [31:0]          bram_rddata,
   output logic                 bram_en,
   output logic                 bram_rst,
   output logic [3:0]           bram_we,
   output logic                 ev_valid,
   input  logic                 ev_ready,
   output logic [2*COORD_W:0]   ev_data
`ifdef DVS_EVENT_TIMESTAMP_EN
   ,output logic [TS_W-1:0]     ev_ts
`endif
);

   localparam int EV_W  = 1 + 2*COORD_W;
   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(LINE_WORDS - 1);
   localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(NUM_LINES - 1);

   state_t             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [COORD_W-1:0] y_q;
   logic [COL_W-1:0]   hi_col_q, lo_col_q;
   logic               line_done_q, frame_done_q, overrun_q;

   logic               hi_ev, lo_ev, emit, slot_load, slot_free;
   logic [EV_W-1:0]    ev_d;

   // Only the colour fields steer the scan; ref and pixel values are unused.
   logic unused_rddata;
   assign unused_rddata = ^{bram_rddata[HI_REF_LSB +: REF_W], bram_rddata[HI_PIX_LSB +: PIX_W],
                            bram_rddata[LO_REF_LSB +: REF_W], bram_rddata[LO_PIX_LSB +: PIX_W]};

   assign hi_ev = col_is_event(hi_col_q);
   assign lo_ev = col_is_event(lo_col_q);

   always_comb begin
      emit = 1'b0;
      ev_d = '0;
      if (state_q == S_EMIT_HI && hi_ev) begin
         emit = 1'b1;
         ev_d = {hi_col_q == COL_POS, y_q, COORD_W'({idx_q, 1'b0})};
      end else if (state_q == S_EMIT_LO && lo_ev) begin
         emit = 1'b1;
         ev_d = {lo_col_q == COL_POS, y_q, COORD_W'({idx_q, 1'b1})};
      end
   end

   assign slot_load = emit && slot_free && !frame_start;

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         addr_q       <= '0;
         y_q          <= '0;
         hi_col_q     <= COL_NONE;
         lo_col_q     <= COL_NONE;
         line_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         line_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (frame_start) begin
            y_q       <= '0;
            overrun_q <= 1'b0;
            if (line_ready) begin
               idx_q   <= '0;
               addr_q  <= '0;
               state_q <= S_FETCH;
            end else begin
               state_q <= S_IDLE;
            end
         end else begin
            if (line_ready && state_q != S_IDLE) overrun_q <= 1'b1;
            case (state_q)
               S_IDLE: begin
                  if (line_ready) begin
                     idx_q   <= '0;
                     addr_q  <= '0;
                     state_q <= S_FETCH;
                  end
               end
               S_FETCH: state_q <= S_WAIT;
               S_WAIT: begin
                  hi_col_q <= bram_rddata[HI_COL_LSB +: COL_W];
                  lo_col_q <= bram_rddata[LO_COL_LSB +: COL_W];
                  state_q  <= S_EMIT_HI;
               end
               S_EMIT_HI: begin
                  if (!emit || slot_free) state_q <= S_EMIT_LO;
               end
               S_EMIT_LO: begin
                  if (!emit || slot_free) begin
                     if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                     end else begin
                        idx_q   <= idx_q + 1'b1;
                        addr_q  <= addr_q + 1'b1;
                        state_q <= S_FETCH;
                     end
                  end
               end
               S_DONE: begin
                  line_done_q <= 1'b1;
                  if (y_q == LAST_Y) begin
                     y_q          <= '0;
                     frame_done_q <= 1'b1;
                  end else begin
                     y_q <= y_q + 1'b1;
                  end
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

`ifdef DVS_EVENT_TIMESTAMP_EN
   localparam int SLOT_W = TS_W + EV_W;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [SLOT_W-1:0] slot_in, slot_out;

   assign ts_d = ts_q + 1'b1;

   always_ff @(posedge pclk or posedge reset) begin
      if (reset)            ts_q <= '0;
      else if (frame_start) ts_q <= '0;
      else                  ts_q <= ts_d;
   end

   // Capture the count as it will read on the edge that raises ev_valid.
   assign slot_in = {ts_d, ev_d};
   assign {ev_ts, ev_data} = slot_out;
`else
   localparam int SLOT_W = EV_W;
   logic [SLOT_W-1:0] slot_in, slot_out;

   assign slot_in = ev_d;
   assign ev_data = slot_out;
`endif

   dvs_event_slot #(.W(SLOT_W)) u_slot (
      .clk_i   (pclk),
      .rst_i   (reset),
      .flush_i (frame_start),
      .load_i  (slot_load),
      .data_i  (slot_in),
      .ready_i (ev_ready),
      .valid_o (ev_valid),
      .data_o  (slot_out),
      .free_o  (slot_free)
   );

   assign line_done    = line_done_q;
   assign frame_done   = frame_done_q;
   assign line_overrun = overrun_q;
   assign bram_addr    = addr_q;
   assign bram_clk     = pclk;
   assign bram_en      = !reset;
   assign bram_rst     = reset;
   assign bram_we      = 4'b0000;

endmodule

// File: tb/tb_dvs_event_reader.sv
// Scoreboard bench for dvs_event_reader: a line-level model queues expected
// events, a negedge monitor pops them on every stream transfer.
module tb_dvs_event_reader;

   localparam int LW = 64;
   localparam int NL = 128;
   localparam int AW = 17;
   localparam int CW = 7;
   localparam int EW = 1 + 2*CW;

   logic          pclk = 1'b0;
   logic          reset = 1'b1;
   logic          frame_start = 1'b0;
   logic          line_ready = 1'b0;
   logic          ev_ready = 1'b0;
   logic [31:0]   bram_rddata = '0;
   logic          line_done, frame_done, line_overrun;
   logic [AW-1:0] bram_addr;
   logic          bram_clk, bram_en, bram_rst;
   logic [3:0]    bram_we;
   logic          ev_valid;
   logic [EW-1:0] ev_data;
`ifdef DVS_EVENT_TIMESTAMP_EN
   logic [15:0]   ev_ts;
`endif

   always #5 pclk = ~pclk;

   dvs_event_reader dut (
      .pclk         (pclk),
      .reset        (reset),
      .frame_start  (frame_start),
      .line_ready   (line_ready),
      .line_done    (line_done),
      .frame_done   (frame_done),
      .line_overrun (line_overrun),
      .bram_addr    (bram_addr),
      .bram_clk     (bram_clk),
      .bram_rddata  (bram_rddata),
      .bram_en      (bram_en),
      .bram_rst     (bram_rst),
      .bram_we      (bram_we),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_data      (ev_data)
`ifdef DVS_EVENT_TIMESTAMP_EN
      ,.ev_ts       (ev_ts)
`endif
   );

   // BRAM model: address sampled at an edge, data returned one cycle later.
   logic [31:0]   mem [LW];
   logic [AW-1:0] addr_s = '0;
   always @(negedge pclk) addr_s = bram_addr;
   always @(posedge pclk) begin
      #1;
      bram_rddata = mem[addr_s[5:0]];
   end

   int ready_mode = 1;  // 0 = low, 1 = high, 2 = random
   always @(posedge pclk) begin
      #1;
      ev_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
   end

   logic [EW-1:0] exp_q [$];
   int n_vec = 0;
   int n_err = 0;
   int y_m = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: scoreboard pop on transfer, plus hold check while stalled.
   logic          prev_stall = 1'b0;
   logic          prev_fs = 1'b0;
   logic          prev_rst = 1'b1;
   logic [EW-1:0] prev_data = '0;
   always @(negedge pclk) begin
      if (prev_stall && !prev_fs && !prev_rst && !reset) begin
         chk("hold_valid", ev_valid, 1);
         chk("hold_data", ev_data, prev_data);
      end
      if (ev_valid && ev_ready && !reset) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got %0h expected none at %0t", ev_data, $time);
         end else begin
            chk("event", ev_data, exp_q.pop_front());
         end
      end
      prev_stall = ev_valid && !ev_ready;
      prev_data  = ev_data;
      prev_fs    = frame_start;
      prev_rst   = reset;
   end

   // Reference: every 01/10 colour, upper half then lower, word by word.
   task automatic model_line();
      logic [1:0] col;
      for (int w = 0; w < LW; w++) begin
         for (int h = 0; h < 2; h++) begin
            col = (h == 0) ? mem[w][23:22] : mem[w][7:6];
            if (col == 2'b01 || col == 2'b10)
               exp_q.push_back({col == 2'b01, 7'(y_m), 7'(2*w + h)});
         end
      end
      y_m = (y_m + 1) % NL;
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic clear_mem();
      for (int w = 0; w < LW; w++) mem[w] = '0;
   endtask

   function automatic logic [1:0] rand_col();
      int r;
      r = $urandom_range(0, 7);
      return (r < 5) ? 2'b00 : (r == 5) ? 2'b01 : (r == 6) ? 2'b10 : 2'b11;
   endfunction

   task automatic rand_mem();
      logic [31:0] v;
      for (int w = 0; w < LW; w++) begin
         v = $urandom;
         v[23:22] = rand_col();
         v[7:6]   = rand_col();
         mem[w] = v;
      end
   endtask

   task automatic pulse_line();
      line_ready = 1'b1;
      tick();
      line_ready = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (!line_done && n < budget) begin
         tick();
         n++;
      end
      if (!line_done) begin
         n_vec++;
         n_err++;
         $display("FAIL line_done_timeout: got none expected pulse within %0d cycles", budget);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic run_line(input bit check_time);
      int n;
      model_line();
      pulse_line();
      wait_done(4000, n);
      if (check_time) chk("line_cycles", n, 4*LW + 1);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  seen;
      clear_mem();

      repeat (3) tick();
      chk("rst_bram_en", bram_en, 0);
      chk("rst_bram_rst", bram_rst, 1);
      chk("rst_ev_valid", ev_valid, 0);
      chk("rst_line_done", line_done, 0);
      chk("rst_addr", bram_addr, 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_ev_valid", ev_valid, 0);
         chk("idle_line_done", line_done, 0);
      end
      chk("idle_frame_done", frame_done, 0);
      chk("idle_overrun", line_overrun, 0);
      chk("idle_we", bram_we, 0);
      chk("idle_en", bram_en, 1);
      chk("idle_rst", bram_rst, 0);
      chk("idle_data", ev_data, 0);

      // Five empty lines, then y = 5 with one positive event at x = 6.
      for (int i = 0; i < 5; i++) run_line(1);
      mem[3] = 32'h0040_0000;
      run_line(1);
      drain();

      // frame_start with line_ready together, backpressure, reserved colour.
      clear_mem();
      mem[0] = 32'h0040_0080;
      mem[1] = 32'h00C0_00C0;
      ready_mode = 0;
      tick();
      tick();
      frame_start = 1'b1;
      line_ready  = 1'b1;
      y_m = 0;
      model_line();
      tick();
      frame_start = 1'b0;
      line_ready  = 1'b0;
      tick();
      tick();
      chk("latency_early", ev_valid, 0);
      tick();
      chk("latency_valid", ev_valid, 1);
      for (int i = 0; i < 10; i++) begin
         chk("stall_data", ev_data, 15'h4000);
         tick();
      end
      ready_mode = 1;
      wait_done(4000, n);
      drain();

      // Full frame of empty lines; frame_done only with the last line_done.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      y_m = 0;
      clear_mem();
      for (int i = 0; i < NL; i++) begin
         model_line();
         pulse_line();
         wait_done(4000, n);
         chk("frame_done", frame_done, (i == NL - 1));
         if (i == 0) chk("empty_line_cycles", n, 4*LW + 1);
      end
      mem[10] = 32'h0080_0040;
      run_line(1);
      drain();

      // Random lines with random backpressure.
      ready_mode = 2;
      for (int i = 0; i < 6; i++) begin
         rand_mem();
         run_line(0);
      end
      drain();

      // Second line_ready mid-scan: flagged, scan unaffected.
      ready_mode = 1;
      rand_mem();
      model_line();
      pulse_line();
      repeat (30) tick();
      line_ready = 1'b1;
      tick();
      line_ready = 1'b0;
      chk("overrun_set", line_overrun, 1);
      wait_done(4000, n);
      chk("overrun_sticky", line_overrun, 1);
      drain();

      // frame_start while stuck in EMIT_HI with a pending event.
      clear_mem();
      mem[0] = 32'h0040_0000;
      mem[1] = 32'h0040_0000;
      ready_mode = 0;
      tick();
      tick();
      model_line();
      pulse_line();
      repeat (8) tick();
      chk("abort_pending", ev_valid, 1);
      frame_start = 1'b1;
      exp_q.delete();
      y_m = 0;
      tick();
      frame_start = 1'b0;
      chk("abort_ev_valid", ev_valid, 0);
      chk("abort_overrun", line_overrun, 0);
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (line_done) seen = 1'b1;
      end
      chk("abort_no_line_done", seen, 0);

      // Back in IDLE with y = 0: next line has normal first-event latency.
      ready_mode = 1;
      clear_mem();
      mem[0] = 32'h0040_0000;
      model_line();
      pulse_line();
      tick();
      tick();
      chk("restart_early", ev_valid, 0);
      tick();
      chk("restart_valid", ev_valid, 1);
      wait_done(4000, n);
      drain();

`ifdef DVS_EVENT_TIMESTAMP_EN
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      y_m = 0;
      repeat (9) tick();
      model_line();
      line_ready = 1'b1;
      tick();
      line_ready = 1'b0;
      repeat (3) tick();
      chk("ts_valid", ev_valid, 1);
      chk("ts_value", ev_ts, 13);
      wait_done(4000, n);
      drain();
`endif

      // Asynchronous reset in the middle of a line.
      rand_mem();
      mem[0] = 32'h0040_0000;
      model_line();
      pulse_line();
      repeat (20) tick();
      reset = 1'b1;
      #1;
      chk("arst_ev_valid", ev_valid, 0);
      chk("arst_bram_en", bram_en, 0);
      chk("arst_bram_rst", bram_rst, 1);
      chk("arst_addr", bram_addr, 0);
      chk("arst_overrun", line_overrun, 0);
      exp_q.delete();
      y_m = 0;
      tick();
      reset = 1'b0;
      tick();
      clear_mem();
      mem[2] = 32'h0000_0040;
      run_line(1);
      drain();

      repeat (5) tick();
      chk("leftover", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
